aes_round_ctrl: RTL

Sequencing controller that sits directly upstream of the AES-128 datapath core and turns a single-block encryption request into the 11-cycle round schedule the core expects. It accepts plaintext and key over a valid/ready handshake and holds them stable for the core. It drives the core's accept/round/enable controls cycle by cycle, captures the core's registered ciphertext, and presents it over a valid/ready output handshake. One block is in flight at a time.

---
 rtl/aes_round_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one AES-128 block through the iterative datapath core.
// Accepts plaintext/key over valid/ready, drives the core's accept/round/enable
// controls over the 11-cycle schedule, captures the ciphertext and offers it
// over a valid/ready output handshake. One block in flight at a time.
// Optional feature: define AES_CTRL_ABORT_EN to add an abort input that returns
// the controller to IDLE from any busy state and discards the block.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rstn,
`ifdef AES_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_plain,
    input  logic [127:0] in_key,
    output logic [127:0] core_plain,
    output logic [127:0] core_key,
    output logic         core_accept,
    output logic [3:0]   core_rnd_no,
    output logic         core_enb_sb,
    output logic         core_enb_mc,
    input  logic [127:0] core_cipher,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
    localparam logic [3:0] PRE_LAST = 4'(NUM_ROUNDS - 1);

    state_t       state_reg;
    logic         in_ready_reg;
    logic         busy_reg;
    logic         accept_reg;
    logic [3:0]   rnd_reg;        // round counter, doubles as the core's round number
    logic         enb_sb_reg;
    logic         enb_mc_reg;
    logic         out_valid_reg;
    logic [127:0] out_data_reg;
    logic [127:0] plain_reg;
    logic [127:0] key_reg;
    logic         abort_req;

`ifdef AES_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_ready    = in_ready_reg;
    assign busy        = busy_reg;
    assign core_accept = accept_reg;
    assign core_rnd_no = rnd_reg;
    assign core_enb_sb = enb_sb_reg;
    assign core_enb_mc = enb_mc_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign core_plain  = plain_reg;
    assign core_key    = key_reg;

    // State machine with every output registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            accept_reg    <= 1'b0;
            rnd_reg       <= 4'd0;
            enb_sb_reg    <= 1'b0;
            enb_mc_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            plain_reg     <= '0;
            key_reg       <= '0;
        end else if (abort_req && state_reg != IDLE) begin
            // Drop the block in flight; the latched operands stay until the next request.
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            accept_reg    <= 1'b0;
            rnd_reg       <= 4'd0;
            enb_sb_reg    <= 1'b0;
            enb_mc_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rnd_reg <= 4'd0;
                    if (in_valid && in_ready_reg) begin
                        plain_reg    <= in_plain;
                        key_reg      <= in_key;
                        state_reg    <= LOAD;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        accept_reg   <= 1'b1;   // initial AddRoundKey with round 0
                    end
                end
                LOAD: begin
                    state_reg  <= ROUND;
                    accept_reg <= 1'b0;
                    rnd_reg    <= 4'd1;
                    enb_sb_reg <= 1'b1;
                    enb_mc_reg <= 1'b1;
                end
                ROUND: begin
                    if (rnd_reg == PRE_LAST) begin
                        // Last round skips MixColumns.
                        state_reg  <= FINAL;
                        rnd_reg    <= LAST_RND;
                        enb_mc_reg <= 1'b0;
                    end else begin
                        rnd_reg <= rnd_reg + 4'd1;
                    end
                end
                FINAL: begin
                    state_reg  <= CAPTURE;
                    rnd_reg    <= 4'd0;
                    enb_sb_reg <= 1'b0;
                    enb_mc_reg <= 1'b0;
                end
                CAPTURE: begin
                    // The core register holds the ciphertext one edge after FINAL.
                    state_reg     <= DONE;
                    out_data_reg  <= core_cipher;
                    out_valid_reg <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                    accept_reg    <= 1'b0;
                    rnd_reg       <= 4'd0;
                    enb_sb_reg    <= 1'b0;
                    enb_mc_reg    <= 1'b0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
